// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - KxK stride-1 window beat sequencer; optional stall counter via SEQ_STALL_CNT_EN
module conv_window_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [DIM_W-1:0]  kernel_size,
    input  logic              stall,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] ker_addr,
    output logic              beat_valid,
    output logic              beat_first,
    output logic              beat_last,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [DIM_W-1:0]   cfg_w, cfg_h, cfg_k;
    logic [DIM_W-1:0]   kr, kc;
    // line_base = orow*W, win_base = line_base + ocol, row_base = win_base + kr*W
    logic [ADDR_W-1:0]  line_base, win_base, row_base;

    logic [DIM_W-1:0]   k_m1, col_max, row_max;
    logic [ADDR_W-1:0]  w_a;
    logic               cfg_bad, kc_end, kr_end, col_end, row_end;

    // Window limits derived from the latched configuration
    always_comb begin
        k_m1    = cfg_k - 1'b1;
        col_max = cfg_w - cfg_k;
        row_max = cfg_h - cfg_k;
        w_a     = ADDR_W'(cfg_w);
        kc_end  = (kc == k_m1);
        kr_end  = (kr == k_m1);
        col_end = (out_col == col_max);
        row_end = (out_row == row_max);
        cfg_bad = (kernel_size == '0) || (kernel_size > img_width) || (kernel_size > img_height);
    end

    assign beat_valid = (state == S_RUN) && !stall;

    // Control FSM and beat generator; outputs only advance on a transferred beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cfg_w      <= '0;
            cfg_h      <= '0;
            cfg_k      <= '0;
            kr         <= '0;
            kc         <= '0;
            line_base  <= '0;
            win_base   <= '0;
            row_base   <= '0;
            img_addr   <= '0;
            ker_addr   <= '0;
            beat_first <= 1'b0;
            beat_last  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                        end else begin
                            state      <= S_RUN;
                            cfg_w      <= img_width;
                            cfg_h      <= img_height;
                            cfg_k      <= kernel_size;
                            kr         <= '0;
                            kc         <= '0;
                            line_base  <= '0;
                            win_base   <= '0;
                            row_base   <= '0;
                            img_addr   <= '0;
                            ker_addr   <= '0;
                            beat_first <= 1'b1;
                            beat_last  <= (kernel_size == DIM_W'(1));
                            out_row    <= '0;
                            out_col    <= '0;
                            busy       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (!kc_end) begin
                            kc         <= kc + 1'b1;
                            img_addr   <= img_addr + 1'b1;
                            ker_addr   <= ker_addr + 1'b1;
                            beat_first <= 1'b0;
                            beat_last  <= kr_end && ((kc + 1'b1) == k_m1);
                        end else if (!kr_end) begin
                            kc         <= '0;
                            kr         <= kr + 1'b1;
                            row_base   <= row_base + w_a;
                            img_addr   <= row_base + w_a;
                            ker_addr   <= ker_addr + 1'b1;
                            beat_first <= 1'b0;
                            beat_last  <= 1'b0;
                        end else begin
                            kc       <= '0;
                            kr       <= '0;
                            ker_addr <= '0;
                            if (!col_end) begin
                                out_col    <= out_col + 1'b1;
                                win_base   <= win_base + 1'b1;
                                row_base   <= win_base + 1'b1;
                                img_addr   <= win_base + 1'b1;
                                beat_first <= 1'b1;
                                beat_last  <= (cfg_k == DIM_W'(1));
                            end else if (!row_end) begin
                                out_col    <= '0;
                                out_row    <= out_row + 1'b1;
                                line_base  <= line_base + w_a;
                                win_base   <= line_base + w_a;
                                row_base   <= line_base + w_a;
                                img_addr   <= line_base + w_a;
                                beat_first <= 1'b1;
                                beat_last  <= (cfg_k == DIM_W'(1));
                            end else begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                beat_first <= 1'b0;
                                beat_last  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    done    <= 1'b0;
                    cfg_err <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_STALL_CNT_EN
    // Saturating count of stalled RUN cycles, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == S_RUN && stall && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - directed self-checking bench for conv_window_sequencer
module tb_conv_window_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [7:0]  img_width, img_height, kernel_size;
    logic [15:0] img_addr, ker_addr;
    logic        beat_valid, beat_first, beat_last, busy, done, cfg_err;
    logic [7:0]  out_row, out_col;
`ifdef SEQ_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    conv_window_sequencer #(.ADDR_W(16), .DIM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height), .kernel_size(kernel_size),
        .stall(stall),
        .img_addr(img_addr), .ker_addr(ker_addr),
        .beat_valid(beat_valid), .beat_first(beat_first), .beat_last(beat_last),
        .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef SEQ_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-cycle capture, index n = cycles after the start edge
    logic [15:0] c_img [64];
    logic [15:0] c_ker [64];
    logic [7:0]  c_row [64];
    logic [7:0]  c_col [64];
    logic        c_valid [64];
    logic        c_first [64];
    logic        c_last  [64];
    logic        c_busy  [64];
    logic        c_done  [64];
    logic        c_err   [64];

    // expected beat list
    logic [49:0] e_beat [64];
    int          e_n;

    task automatic build_exp(input int w, input int h, input int k);
        e_n = 0;
        for (int orow = 0; orow <= h - k; orow++)
            for (int ocol = 0; ocol <= w - k; ocol++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        e_beat[e_n] = {16'((orow + kr) * w + ocol + kc), 16'(kr * k + kc),
                                       1'(kr == 0 && kc == 0), 1'(kr == k - 1 && kc == k - 1),
                                       8'(orow), 8'(ocol)};
                        e_n++;
                    end
    endtask

    task automatic do_start(input logic [7:0] w, input logic [7:0] h, input logic [7:0] k);
        @(negedge clk);
        img_width = w; img_height = h; kernel_size = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic capture(input int ncyc, input int st_lo, input int st_hi,
                           input int rst_at, input int restart_at, input logic [7:0] rw);
        for (int n = 1; n <= ncyc; n++) begin
            stall = (n >= st_lo && n <= st_hi);
            rst   = (n == rst_at);
            start = (n == restart_at);
            if (n == restart_at) img_width = rw;
            #1;
            c_img[n] = img_addr;  c_ker[n] = ker_addr;
            c_row[n] = out_row;   c_col[n] = out_col;
            c_valid[n] = beat_valid; c_first[n] = beat_first; c_last[n] = beat_last;
            c_busy[n] = busy; c_done[n] = done; c_err[n] = cfg_err;
            @(negedge clk);
        end
        stall = 1'b0; rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        img_width = 8'd0; img_height = 8'd0; kernel_size = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({img_addr, ker_addr, beat_valid, beat_first, beat_last, out_row, out_col, busy, done, cfg_err} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0",
                     {img_addr, ker_addr, beat_valid, beat_first, beat_last, out_row, out_col, busy, done, cfg_err});
        end
`ifdef SEQ_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cycles got %0d expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_basic;
        int e;
        build_exp(4, 4, 3);
        do_start(8'd4, 8'd4, 8'd3);
        capture(40, 1000, 0, 0, 0, 8'd0);
        e = 0;
        for (int n = 1; n <= 40; n++) begin
            checks++;
            if (c_valid[n] !== (n <= 36) || c_busy[n] !== (n <= 36) || c_done[n] !== (n == 37)) begin
                errors++;
                $display("FAIL basic_timing cycle %0d got valid=%b busy=%b done=%b", n, c_valid[n], c_busy[n], c_done[n]);
            end
            if (c_valid[n]) begin
                checks++;
                if (e >= e_n) begin
                    errors++; $display("FAIL basic_beat extra beat at cycle %0d", n);
                end else if ({c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]} !== e_beat[e]) begin
                    errors++;
                    $display("FAIL basic_beat %0d got %h expected %h", e,
                             {c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]}, e_beat[e]);
                end
                e++;
            end
        end
        checks++;
        if (e !== 36) begin errors++; $display("FAIL basic_count got %0d expected 36", e); end
        checks++;
        if (c_img[28] !== 16'd5 || c_first[28] !== 1'b1) begin
            errors++; $display("FAIL basic_win11 got img=%0d first=%b expected img=5 first=1", c_img[28], c_first[28]);
        end
        checks++;
        if (c_img[9] !== 16'd10 || c_ker[9] !== 16'd8 || c_last[9] !== 1'b1) begin
            errors++; $display("FAIL basic_win0_last got img=%0d ker=%0d last=%b expected 10 8 1", c_img[9], c_ker[9], c_last[9]);
        end
    endtask

    task automatic test_k1;
        build_exp(2, 2, 1);
        do_start(8'd2, 8'd2, 8'd1);
        capture(6, 1000, 0, 0, 0, 8'd0);
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (c_valid[n] !== 1'b1 || c_img[n] !== 16'(n - 1) || c_first[n] !== 1'b1 || c_last[n] !== 1'b1) begin
                errors++;
                $display("FAIL k1_beat cycle %0d got v=%b img=%0d f=%b l=%b expected 1 %0d 1 1",
                         n, c_valid[n], c_img[n], c_first[n], c_last[n], n - 1);
            end
        end
        checks++;
        if (c_valid[5] !== 1'b0 || c_done[5] !== 1'b1 || c_err[5] !== 1'b0) begin
            errors++; $display("FAIL k1_done got v=%b done=%b err=%b expected 0 1 0", c_valid[5], c_done[5], c_err[5]);
        end
    endtask

    task automatic test_illegal;
        do_start(8'd4, 8'd4, 8'd5);
        capture(4, 1000, 0, 0, 0, 8'd0);
        checks++;
        if (c_done[1] !== 1'b1 || c_err[1] !== 1'b1 || c_busy[1] !== 1'b0) begin
            errors++; $display("FAIL illegal_done got done=%b err=%b busy=%b expected 1 1 0", c_done[1], c_err[1], c_busy[1]);
        end
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (c_valid[n] !== 1'b0) begin errors++; $display("FAIL illegal_valid cycle %0d got %b expected 0", n, c_valid[n]); end
        end
        checks++;
        if (c_done[2] !== 1'b0 || c_err[2] !== 1'b0) begin
            errors++; $display("FAIL illegal_idle got done=%b err=%b expected 0 0", c_done[2], c_err[2]);
        end
        do_start(8'd4, 8'd4, 8'd0);
        capture(2, 1000, 0, 0, 0, 8'd0);
        checks++;
        if (c_done[1] !== 1'b1 || c_err[1] !== 1'b1 || c_valid[1] !== 1'b0) begin
            errors++; $display("FAIL illegal_k0 got done=%b err=%b v=%b expected 1 1 0", c_done[1], c_err[1], c_valid[1]);
        end
    endtask

    task automatic test_stall;
        int e;
        build_exp(4, 4, 3);
        do_start(8'd4, 8'd4, 8'd3);
        capture(42, 5, 7, 0, 0, 8'd0);
        for (int n = 5; n <= 7; n++) begin
            checks++;
            if (c_valid[n] !== 1'b0 || c_img[n] !== 16'd5 || c_ker[n] !== 16'd4) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b img=%0d ker=%0d expected 0 5 4", n, c_valid[n], c_img[n], c_ker[n]);
            end
        end
        e = 0;
        for (int n = 1; n <= 42; n++) begin
            if (c_valid[n]) begin
                checks++;
                if (e >= e_n) begin
                    errors++; $display("FAIL stall_beat extra beat at cycle %0d", n);
                end else if ({c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]} !== e_beat[e]) begin
                    errors++;
                    $display("FAIL stall_beat %0d got %h expected %h", e,
                             {c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]}, e_beat[e]);
                end
                e++;
            end
        end
        checks++;
        if (e !== 36) begin errors++; $display("FAIL stall_count got %0d expected 36", e); end
        checks++;
        if (c_done[40] !== 1'b1 || c_done[39] !== 1'b0) begin
            errors++; $display("FAIL stall_done got done39=%b done40=%b expected 0 1", c_done[39], c_done[40]);
        end
`ifdef SEQ_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++; $display("FAIL stall_cycles got %0d expected 3", stall_cycles);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int e;
        do_start(8'd4, 8'd4, 8'd3);
        capture(14, 1000, 0, 11, 0, 8'd0);
        checks++;
        if (c_valid[11] !== 1'b1 || c_img[11] !== 16'd2 || c_ker[11] !== 16'd1 || c_col[11] !== 8'd1) begin
            errors++;
            $display("FAIL rstmid_beat10 got v=%b img=%0d ker=%0d col=%0d expected 1 2 1 1", c_valid[11], c_img[11], c_ker[11], c_col[11]);
        end
        checks++;
        if ({c_img[12], c_ker[12], c_valid[12], c_first[12], c_last[12], c_row[12], c_col[12], c_busy[12], c_done[12], c_err[12]} !== 53'd0) begin
            errors++;
            $display("FAIL rstmid_idle got %h expected 0",
                     {c_img[12], c_ker[12], c_valid[12], c_first[12], c_last[12], c_row[12], c_col[12], c_busy[12], c_done[12], c_err[12]});
        end
        for (int n = 12; n <= 14; n++) begin
            checks++;
            if (c_done[n] !== 1'b0 || c_valid[n] !== 1'b0) begin
                errors++; $display("FAIL rstmid_nodone cycle %0d got done=%b v=%b expected 0 0", n, c_done[n], c_valid[n]);
            end
        end
        build_exp(4, 4, 3);
        do_start(8'd4, 8'd4, 8'd3);
        capture(38, 1000, 0, 0, 0, 8'd0);
        e = 0;
        for (int n = 1; n <= 38; n++) begin
            if (c_valid[n]) begin
                checks++;
                if (e >= e_n || {c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]} !== e_beat[e]) begin
                    errors++;
                    $display("FAIL rstmid_replay beat %0d cycle %0d got %h", e, n,
                             {c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]});
                end
                e++;
            end
        end
        checks++;
        if (e !== 36 || c_done[37] !== 1'b1) begin
            errors++; $display("FAIL rstmid_replay_end got beats=%0d done=%b expected 36 1", e, c_done[37]);
        end
    endtask

    task automatic test_start_busy;
        int e;
        build_exp(4, 4, 3);
        do_start(8'd4, 8'd4, 8'd3);
        capture(40, 1000, 0, 0, 5, 8'd6);
        e = 0;
        for (int n = 1; n <= 40; n++) begin
            if (c_valid[n]) begin
                checks++;
                if (e >= e_n || {c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]} !== e_beat[e]) begin
                    errors++;
                    $display("FAIL busy_start beat %0d cycle %0d got %h", e, n,
                             {c_img[n], c_ker[n], c_first[n], c_last[n], c_row[n], c_col[n]});
                end
                e++;
            end
        end
        checks++;
        if (e !== 36 || c_done[37] !== 1'b1 || c_valid[37] !== 1'b0) begin
            errors++; $display("FAIL busy_start_end got beats=%0d done=%b expected 36 1", e, c_done[37]);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_k1;
        test_illegal;
        test_stall;
        test_reset_mid;
        test_start_busy;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Issuing side of the accumulate-beat stream used by the convolution core.
- On a start pulse, walks every valid KxK window of a row-major image, stride 1, no padding.
- Per beat: emits an image address, a kernel address and a valid pulse to the memories, the multiplier and the accumulator.
- Marks the first and last beat of each window, reports the output pixel coordinate, and signals completion.
- Sits between the control registers and the multiply/accumulate datapath.

Parameters:
ADDR_W, 16, width of img_addr and ker_addr; addresses wrap modulo 2^ADDR_W.
DIM_W, 8, width of img_width, img_height, kernel_size, out_row, out_col.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
img_width  in  DIM_W  image width W; sampled with start.
img_height  in  DIM_W  image height H; sampled with start.
kernel_size  in  DIM_W  kernel side K; sampled with start.
stall  in  1  downstream hold; freezes the sequencer while high.
img_addr  out  ADDR_W  (orow+kr)*W + (ocol+kc).
ker_addr  out  ADDR_W  kr*K + kc.
beat_valid  out  1  beat transferred at an edge where beat_valid=1.
beat_first  out  1  qualifies beat kr=0, kc=0.
beat_last  out  1  qualifies beat kr=K-1, kc=K-1.
out_row  out  DIM_W  orow of the current window.
out_col  out  DIM_W  ocol of the current window.
busy  out  1  high in RUN.
done  out  1  one-cycle completion pulse.
cfg_err  out  1  high with done when the configuration is illegal.

Behaviour:
- Reset: state IDLE; all outputs 0; counters kr, kc, orow, ocol = 0.
- States: IDLE, RUN, DONE.
- IDLE to RUN: start=1 with legal config. Latch W, H, K; clear counters; beat 0 is presented the next cycle.
- IDLE to DONE: start=1 with K=0, K>W or K>H. cfg_err=1 during DONE; no beat is ever issued.
- beat_valid = (state==RUN) & ~stall. This is combinational from registered state.
- All other outputs are registered and only advance at an edge where beat_valid=1.
- Stall behaviour: while stall=1, addresses, flags and counters hold and beat_valid=0, so no beat is duplicated.
- Iteration order: kc fastest, then kr, then ocol, then orow.
- Window wrap: at kc=K-1, kc wraps to 0 and kr increments. At kr=K-1 as well, kr wraps to 0 and ocol increments.
- Row wrap: at ocol=W-K, ocol wraps to 0 and orow increments.
- Addresses use incremental adders only: a row base plus column offset, with no multiplier.
- Total beats: (H-K+1)*(W-K+1)*K*K. With no stall they are issued on consecutive cycles.
- RUN to DONE: on the edge that transfers the beat with beat_last=1 and orow=H-K, ocol=W-K.
- DONE lasts one cycle: done=1, busy=0, then return to IDLE. start is ignored in RUN and DONE.
- K=1: beat_first=beat_last=1 on every beat.
- rst during RUN: the next cycle is IDLE with outputs 0. A partially issued window is abandoned and there is no done pulse.
- Latched config is immune to input changes during RUN.

Optional Feature:
Macro SEQ_STALL_CNT_EN.
- Defined: adds output stall_cycles[31:0]. It counts cycles with state==RUN and stall=1, clears on the accepted start and on rst, saturates at 0xFFFFFFFF, and holds after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic run: W=4, H=4, K=3, stall=0, start at cycle t. Expect 36 beats in cycles t+1 to t+36. Window 0 img_addr is 0,1,2,4,5,6,8,9,10 and ker_addr is 0 to 8. Window (1,1) starts at img_addr 5. done at t+37.
- Single-pixel kernel: W=2, H=2, K=1. Expect 4 beats with img_addr 0,1,2,3, each with beat_first=beat_last=1, then done.
- Illegal config: W=4, H=4, K=5, start. Expect done=cfg_err=1 the next cycle, beat_valid never 1, back in IDLE the following cycle.
- Stall mid-window: W=4, H=4, K=3, stall high for 3 cycles after beat 4. Expect beat_valid=0 and img_addr held at 5 for 3 cycles. Still exactly 36 beats; done at t+40; stall_cycles=3 when SEQ_STALL_CNT_EN is defined.
- Reset mid-run: assert rst at beat 10. Expect IDLE and all outputs 0 the next cycle, with no done. A new start replays the run from beat 0.
- Start while busy: pulse start again during RUN with different W. Expect it ignored; the original 36-beat run completes unchanged.
